// File: rtl/delay_assertion_sched_pkg.sv
// Shared types and helpers for the delayed-implication attempt scheduler.
package delay_assertion_sched_pkg;

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_BUSY = 1'b1
  } slot_state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_PASS = 2'd1,
    RES_FAIL = 2'd2
  } slot_result_e;

  // Bits needed to hold an attempt age in 0..max_delay.
  function automatic int unsigned age_width(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/delay_attempt_slot.sv
// One attempt tracker: FREE/BUSY FSM, age counter and window compare.
module delay_attempt_slot
  import delay_assertion_sched_pkg::*;
#(
  parameter int unsigned MIN_DELAY = 1,
  parameter int unsigned MAX_DELAY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alloc,
  input  logic         b,
  output logic         busy,
  output slot_result_e result
);

  localparam int unsigned AGE_W = age_width(MAX_DELAY);
  localparam logic [AGE_W-1:0] MIN_AGE = AGE_W'(MIN_DELAY);
  localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_DELAY);

  slot_state_e      state, state_nxt;
  logic [AGE_W-1:0] age, age_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_FREE;
      age   <= '0;
    end else begin
      state <= state_nxt;
      age   <= age_nxt;
    end
  end

  // Result is resolved combinationally so it is seen at the edge that retires it.
  always_comb begin
    state_nxt = state;
    age_nxt   = age;
    result    = RES_NONE;
    case (state)
      SLOT_FREE: begin
        if (alloc) begin
          state_nxt = SLOT_BUSY;
          age_nxt   = AGE_W'(1);
        end
      end
      SLOT_BUSY: begin
        if ((age >= MIN_AGE) && b) begin
          result    = RES_PASS;
          state_nxt = SLOT_FREE;
          age_nxt   = '0;
        end else if (age == MAX_AGE) begin
          result    = RES_FAIL;
          state_nxt = SLOT_FREE;
          age_nxt   = '0;
        end else begin
          age_nxt = age + AGE_W'(1);
        end
      end
      default: begin
        state_nxt = SLOT_FREE;
        age_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == SLOT_BUSY);

endmodule

// File: rtl/delay_assertion_scheduler.sv
// Overlapping-attempt controller for a |-> ##[MIN_DELAY:MAX_DELAY] b:
// allocates attempts to shared slots and aggregates their results.
module delay_assertion_scheduler
  import delay_assertion_sched_pkg::*;
#(
  parameter int unsigned MIN_DELAY = 1,
  parameter int unsigned MAX_DELAY = 3,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             a,
  input  logic             b,
  input  logic             clear_counts,
  output logic             assertion_pass,
  output logic             assertion_fail,
  output logic             assertion_active,
  output logic             overflow,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned POP_W = $clog2(NUM_SLOTS + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [NUM_SLOTS-1:0] busy;
  logic [NUM_SLOTS-1:0] alloc;
  logic [NUM_SLOTS-1:0] pass_vec;
  logic [NUM_SLOTS-1:0] fail_vec;
  slot_result_e         result [NUM_SLOTS];
  logic                 start_c;
  logic                 drop_c;
  logic                 active_nxt_c;

  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_slot
    delay_attempt_slot #(
      .MIN_DELAY (MIN_DELAY),
      .MAX_DELAY (MAX_DELAY)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .alloc  (alloc[g]),
      .b      (b),
      .busy   (busy[g]),
      .result (result[g])
    );
    assign pass_vec[g] = (result[g] == RES_PASS);
    assign fail_vec[g] = (result[g] == RES_FAIL);
  end

  // Lowest-index slot that was free before this edge takes the new attempt.
  always_comb begin
    logic found;
    alloc = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (start_c && !found && !busy[i]) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign start_c      = enable & a;
  assign drop_c       = start_c & (&busy);
  assign active_nxt_c = |((busy & ~(pass_vec | fail_vec)) | alloc);

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [POP_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    return (sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(sum);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      assertion_pass   <= 1'b0;
      assertion_fail   <= 1'b0;
      assertion_active <= 1'b0;
      overflow         <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      drop_count       <= '0;
    end else begin
      assertion_pass   <= |pass_vec;
      assertion_fail   <= |fail_vec;
      assertion_active <= active_nxt_c;
      overflow         <= drop_c;
      if (clear_counts) begin
        pass_count <= '0;
        fail_count <= '0;
        drop_count <= '0;
      end else begin
        pass_count <= sat_add(pass_count, popcount(pass_vec));
        fail_count <= sat_add(fail_count, popcount(fail_vec));
        drop_count <= sat_add(drop_count, POP_W'(drop_c));
      end
    end
  end

endmodule

// File: tb/tb_delay_assertion_scheduler.sv
// Directed bench for delay_assertion_scheduler across four parameter sets sharing one stimulus.
module tb_delay_assertion_scheduler;

  logic clk;
  logic rst;
  logic enable;
  logic a;
  logic b;
  logic clear_counts;

  logic        pass_d, fail_d, act_d, ovf_d;
  logic [15:0] pc_d, fc_d, dc_d;
  logic        pass_n2, fail_n2, act_n2, ovf_n2;
  logic [15:0] pc_n2, fc_n2, dc_n2;
  logic        pass_m2, fail_m2, act_m2, ovf_m2;
  logic [15:0] pc_m2, fc_m2, dc_m2;
  logic        pass_s, fail_s, act_s, ovf_s;
  logic [1:0]  pc_s, fc_s, dc_s;

  int checks;
  int errors;

  delay_assertion_scheduler u_dut (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .clear_counts(clear_counts),
    .assertion_pass(pass_d), .assertion_fail(fail_d), .assertion_active(act_d),
    .overflow(ovf_d), .pass_count(pc_d), .fail_count(fc_d), .drop_count(dc_d)
  );

  delay_assertion_scheduler #(.NUM_SLOTS(2)) u_dut_n2 (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .clear_counts(clear_counts),
    .assertion_pass(pass_n2), .assertion_fail(fail_n2), .assertion_active(act_n2),
    .overflow(ovf_n2), .pass_count(pc_n2), .fail_count(fc_n2), .drop_count(dc_n2)
  );

  delay_assertion_scheduler #(.MIN_DELAY(2)) u_dut_m2 (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .clear_counts(clear_counts),
    .assertion_pass(pass_m2), .assertion_fail(fail_m2), .assertion_active(act_m2),
    .overflow(ovf_m2), .pass_count(pc_m2), .fail_count(fc_m2), .drop_count(dc_m2)
  );

  delay_assertion_scheduler #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .clear_counts(clear_counts),
    .assertion_pass(pass_s), .assertion_fail(fail_s), .assertion_active(act_s),
    .overflow(ovf_s), .pass_count(pc_s), .fail_count(fc_s), .drop_count(dc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, then settle just past it.
  task automatic tick(input logic av, input logic bv);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a = 1'b0;
    b = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    enable = 1'b1;
    a = 1'b0;
    b = 1'b0;
    clear_counts = 1'b0;

    // reset state
    do_reset();
    check_eq("rst_pass", 32'(pass_d), 32'd0);
    check_eq("rst_fail", 32'(fail_d), 32'd0);
    check_eq("rst_active", 32'(act_d), 32'd0);
    check_eq("rst_ovf", 32'(ovf_d), 32'd0);
    check_eq("rst_counts", 32'({pc_d, fc_d}) | 32'(dc_d), 32'd0);

    // 1: a@0, b@2 -> pass after edge 2
    tick(1'b1, 1'b0);
    check_eq("t1_active_e0", 32'(act_d), 32'd1);
    tick(1'b0, 1'b0);
    check_eq("t1_pass_e1", 32'(pass_d), 32'd0);
    tick(1'b0, 1'b1);
    check_eq("t1_pass_e2", 32'(pass_d), 32'd1);
    check_eq("t1_pcnt", 32'(pc_d), 32'd1);
    check_eq("t1_fcnt", 32'(fc_d), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t1_pass_e3", 32'(pass_d), 32'd0);
    check_eq("t1_active_e3", 32'(act_d), 32'd0);

    // 2: a@0, b never -> fail after edge 3
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("t2_fail_e2", 32'(fail_d), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t2_fail_e3", 32'(fail_d), 32'd1);
    check_eq("t2_fcnt", 32'(fc_d), 32'd1);
    check_eq("t2_active_e3", 32'(act_d), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t2_fail_e4", 32'(fail_d), 32'd0);

    // 3: a@0,@1, b@2 -> both pass together
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check_eq("t3_pass_e2", 32'(pass_d), 32'd1);
    check_eq("t3_pcnt", 32'(pc_d), 32'd2);
    check_eq("t3_active_e2", 32'(act_d), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t3_pass_e3", 32'(pass_d), 32'd0);
    check_eq("t3_fail_e3", 32'(fail_d), 32'd0);
    clear_counts = 1'b1;
    tick(1'b0, 1'b0);
    clear_counts = 1'b0;
    check_eq("clr_pcnt", 32'(pc_d), 32'd0);

    // clear has priority over a same-edge increment
    do_reset();
    tick(1'b1, 1'b0);
    clear_counts = 1'b1;
    tick(1'b0, 1'b1);
    clear_counts = 1'b0;
    check_eq("clr_prio_pass", 32'(pass_d), 32'd1);
    check_eq("clr_prio_pcnt", 32'(pc_d), 32'd0);

    // 4: two slots, a@0..3 -> drops at 2 and 3, fails at 3 and 4
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_eq("t4_ovf_e1", 32'(ovf_n2), 32'd0);
    tick(1'b1, 1'b0);
    check_eq("t4_ovf_e2", 32'(ovf_n2), 32'd1);
    check_eq("t4_dcnt_e2", 32'(dc_n2), 32'd1);
    tick(1'b1, 1'b0);
    check_eq("t4_ovf_e3", 32'(ovf_n2), 32'd1);
    check_eq("t4_dcnt_e3", 32'(dc_n2), 32'd2);
    check_eq("t4_fail_e3", 32'(fail_n2), 32'd1);
    check_eq("t4_ovf_wide", 32'(ovf_d), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t4_fail_e4", 32'(fail_n2), 32'd1);
    check_eq("t4_fcnt", 32'(fc_n2), 32'd2);
    check_eq("t4_ovf_e4", 32'(ovf_n2), 32'd0);

    // 5: MIN_DELAY=2, b@1 too early -> fail; b@2 -> pass
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check_eq("t5_early_pass", 32'(pass_m2), 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("t5_fail_e3", 32'(fail_m2), 32'd1);
    check_eq("t5_fcnt", 32'(fc_m2), 32'd1);
    check_eq("t5_pcnt0", 32'(pc_m2), 32'd0);
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check_eq("t5_pass_e2", 32'(pass_m2), 32'd1);
    check_eq("t5_pcnt1", 32'(pc_m2), 32'd1);

    // enable low blocks new attempts
    do_reset();
    enable = 1'b0;
    tick(1'b1, 1'b0);
    check_eq("en_active", 32'(act_d), 32'd0);
    tick(1'b1, 1'b1);
    check_eq("en_pass", 32'(pass_d), 32'd0);
    enable = 1'b1;

    // saturation: a and b every cycle -> one pass per edge from edge 1
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    check_eq("sat_wide_pcnt", 32'(pc_d), 32'd5);
    check_eq("sat_narrow_pcnt", 32'(pc_s), 32'd3);
    check_eq("sat_active", 32'(act_d), 32'd1);

    // 6: reset mid-attempt is immediate and silent
    tick(1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t6_active_rst", 32'(act_d), 32'd0);
    check_eq("t6_pcnt_rst", 32'(pc_d), 32'd0);
    check_eq("t6_pass_rst", 32'(pass_d), 32'd0);
    a = 1'b0;
    b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      check_eq("t6_no_pass", 32'(pass_d), 32'd0);
      check_eq("t6_no_fail", 32'(fail_d), 32'd0);
    end
    check_eq("t6_counts", 32'(pc_d) | 32'(fc_d) | 32'(dc_d), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
